// File: rtl/lcd_hex_writer_if.sv
// Host-side and LCD-side signal bundle for lcd_hex_writer.
//   value  : word to display (host -> writer)
//   start  : one-cycle write request (host -> writer)
//   busy   : writer is initialising or writing; start ignored (writer -> host)
//   lcd_rs : register select, 0 = command, 1 = data (writer -> LCD)
//   lcd_rw : read/write, held 0 (writer -> LCD)
//   lcd_e  : enable strobe (writer -> LCD)
//   lcd_db : 8-bit data bus (writer -> LCD)
// Modports: master = host/bench side, slave = writer side.
interface lcd_hex_writer_if;
  logic [31:0] value;
  logic        start;
  logic        busy;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_e;
  logic [7:0]  lcd_db;

  modport master (
    output value, start,
    input  busy, lcd_rs, lcd_rw, lcd_e, lcd_db
  );

  modport slave (
    input  value, start,
    output busy, lcd_rs, lcd_rw, lcd_e, lcd_db
  );
endinterface

// File: rtl/lcd_hex_writer.sv
// Write-only HD44780-compatible character-LCD driver, 8-bit bus mode.
// After reset it waits PWRUP_CYC cycles, sends the init commands
// 0x38, 0x0C, 0x06, 0x01, then idles. A start request latches bus.value
// and writes it as 8 upper-case hex characters at line 1, columns 0-7
// (command 0x80 followed by 8 data bytes, most significant nibble first).
// Every byte: SETUP_CYC cycles with E low, EN_CYC cycles with E high, then
// CMD_WAIT_CYC (CLR_WAIT_CYC after the clear command) cycles with E low.
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : lcd_hex_writer_if.slave (value/start in; busy, lcd_* out)
//
// Optional feature macro: LCD_AUTO_REFRESH_EN
//   When defined, the writer also starts a write on its own whenever, while
//   idle, bus.value differs from the last word latched for display.
module lcd_hex_writer #(
  parameter int unsigned PWRUP_CYC    = 750000,
  parameter int unsigned SETUP_CYC    = 4,
  parameter int unsigned EN_CYC       = 12,
  parameter int unsigned CMD_WAIT_CYC = 2500,
  parameter int unsigned CLR_WAIT_CYC = 82000
) (
  input  logic              clk,
  input  logic              rst_n,
  lcd_hex_writer_if.slave   bus
);

  localparam int unsigned MAX_A   = (PWRUP_CYC > CLR_WAIT_CYC) ? PWRUP_CYC : CLR_WAIT_CYC;
  localparam int unsigned MAX_B   = (CMD_WAIT_CYC > EN_CYC) ? CMD_WAIT_CYC : EN_CYC;
  localparam int unsigned MAX_C   = (MAX_B > SETUP_CYC) ? MAX_B : SETUP_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int unsigned IDX_W   = 4;

  // Counters hold "cycles remaining minus one" for the current phase
  localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_WAIT_CYC - 1);

  localparam logic [IDX_W-1:0] INIT_LAST  = IDX_W'(3);
  localparam logic [IDX_W-1:0] WRITE_LAST = IDX_W'(8);

  typedef enum logic [1:0] {
    ST_PWRUP = 2'd0,
    ST_INIT  = 2'd1,
    ST_IDLE  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PH_SETUP  = 2'd0,
    PH_ENABLE = 2'd1,
    PH_WAIT   = 2'd2
  } phase_e;

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      word_q, word_d;

  logic             busy_q, busy_d;
  logic             rs_q, rs_d;
  logic             e_q, e_d;
  logic [7:0]       db_q, db_d;

  logic             accept;
  logic             clr_byte;
  logic [IDX_W-1:0] last_idx;

  // Upper-case ASCII for one hex nibble
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    hex_ascii = (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
  endfunction

  // RS and DB for byte idx of the init sequence or of the display write
  function automatic logic [8:0] byte_of(input state_e st, input logic [IDX_W-1:0] idx,
                                         input logic [31:0] word);
    logic [2:0] nib_pos;
    logic [3:0] nib;
    nib_pos = 3'(WRITE_LAST - idx);
    nib     = 4'(word >> {nib_pos, 2'b00});
    if (st == ST_INIT) begin
      case (idx)
        IDX_W'(0): byte_of = {1'b0, 8'h38};
        IDX_W'(1): byte_of = {1'b0, 8'h0C};
        IDX_W'(2): byte_of = {1'b0, 8'h06};
        default:   byte_of = {1'b0, 8'h01};
      endcase
    end else if (idx == IDX_W'(0)) begin
      byte_of = {1'b0, 8'h80};
    end else begin
      byte_of = {1'b1, hex_ascii(nib)};
    end
  endfunction

`ifdef LCD_AUTO_REFRESH_EN
  // word_q doubles as the shadow of the last word latched for display
  assign accept = bus.start || (bus.value != word_q);
`else
  assign accept = bus.start;
`endif

  // The clear command needs the long post-strobe wait
  assign clr_byte = !rs_q && (db_q == 8'h01);
  assign last_idx = (state_q == ST_INIT) ? INIT_LAST : WRITE_LAST;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PWRUP;
      phase_q <= PH_SETUP;
      idx_q   <= '0;
      cnt_q   <= PWRUP_LD;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  // Next-state logic: power-up wait, byte sequencing and phase timing
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    case (state_q)
      ST_PWRUP: begin
        if (cnt_q == '0) begin
          state_d = ST_INIT;
          phase_d = PH_SETUP;
          idx_d   = '0;
          cnt_d   = SETUP_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WRITE;
          phase_d = PH_SETUP;
          idx_d   = '0;
          cnt_d   = SETUP_LD;
          word_d  = bus.value;
        end
      end
      default: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          case (phase_q)
            PH_SETUP: begin
              phase_d = PH_ENABLE;
              cnt_d   = EN_LD;
            end
            PH_ENABLE: begin
              phase_d = PH_WAIT;
              cnt_d   = clr_byte ? CLR_LD : CMD_LD;
            end
            default: begin
              phase_d = PH_SETUP;
              cnt_d   = SETUP_LD;
              if (idx_q == last_idx) begin
                state_d = ST_IDLE;
              end else begin
                idx_d = idx_q + IDX_W'(1);
              end
            end
          endcase
        end
      end
    endcase
  end

  // Output logic: next register values derived from the next state
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    e_d    = 1'b0;
    rs_d   = rs_q;
    db_d   = db_q;
    if (state_d == ST_INIT || state_d == ST_WRITE) begin
      e_d          = (phase_d == PH_ENABLE);
      {rs_d, db_d} = byte_of(state_d, idx_d, word_d);
    end
  end

  // Output registers; reset drops E immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b1;
      rs_q   <= 1'b0;
      e_q    <= 1'b0;
      db_q   <= 8'h00;
    end else begin
      busy_q <= busy_d;
      rs_q   <= rs_d;
      e_q    <= e_d;
      db_q   <= db_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.lcd_rs = rs_q;
  assign bus.lcd_rw = 1'b0;
  assign bus.lcd_e  = e_q;
  assign bus.lcd_db = db_q;

endmodule

// File: tb/tb_lcd_hex_writer.sv
// Bench for lcd_hex_writer with short timing parameters. Stimulus steps on the
// falling edge; a reference model decides which requests are accepted and
// queues the bytes the LCD should receive; a monitor pops them on E rising.
module tb_lcd_hex_writer;
  localparam int unsigned PWRUP = 16;
  localparam int unsigned SETUP = 1;
  localparam int unsigned EN    = 2;
  localparam int unsigned CMDW  = 4;
  localparam int unsigned CLRW  = 8;
  localparam int unsigned INIT_CYC  = PWRUP + 3 * (SETUP + EN + CMDW) + SETUP + EN + CLRW;
  localparam int unsigned WR_CYC    = 9 * (SETUP + EN + CMDW);
  localparam int unsigned FIRST_E   = PWRUP + SETUP;
  localparam int          NEVER     = 32'h7fff_ffff;
`ifdef LCD_AUTO_REFRESH_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  lcd_hex_writer_if bus();

  lcd_hex_writer #(
    .PWRUP_CYC   (PWRUP),
    .SETUP_CYC   (SETUP),
    .EN_CYC      (EN),
    .CMD_WAIT_CYC(CMDW),
    .CLR_WAIT_CYC(CLRW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int errors = 0;
  int checks = 0;

  logic [8:0]  exp_q[$];
  logic [8:0]  last_exp = 9'h000;
  logic [8:0]  cur_byte = 9'h000;
  logic [31:0] shadow = 32'h0;
  logic [31:0] cur_v = 32'h0;
  int          idle_from = NEVER;
  int          acc_edge = 0;
  bit          rise_pend = 1'b0;
  int          rise_base = 0;
  logic        e_prev = 1'b0;
  int          e_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] hex(input logic [3:0] n);
    int v;
    v = int'(n);
    return (v < 10) ? 8'(48 + v) : 8'(65 + v - 10);
  endfunction

  task automatic push(input logic [8:0] b);
    exp_q.push_back(b);
    last_exp = b;
  endtask

  // One cycle of stimulus; the model decides acceptance from its own busy view
  task automatic step(input logic [31:0] v, input logic s);
    bit busy_exp;
    bit acc;
    @(negedge clk);
    busy_exp = (rst_n == 1'b0) || (edge_n < idle_from);
    check("busy", 32'(bus.busy), 32'(busy_exp));
    check("rw", 32'(bus.lcd_rw), 32'h0);
    if (!busy_exp) begin
      check("idle_e", 32'(bus.lcd_e), 32'h0);
      check("idle_hold", 32'({bus.lcd_rs, bus.lcd_db}), 32'(last_exp));
    end
    bus.value = v;
    bus.start = s;
    cur_v = v;
    acc = rst_n && !busy_exp && (s || (AUTO && v != shadow));
    if (acc) begin
      shadow    = v;
      acc_edge  = edge_n;
      idle_from = edge_n + 1 + WR_CYC;
      push({1'b0, 8'h80});
      for (int i = 7; i >= 0; i--) push({1'b1, hex(v[i*4 +: 4])});
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle_from = edge_n + INIT_CYC;
    shadow = 32'h0;
    exp_q.delete();
    push({1'b0, 8'h38});
    push({1'b0, 8'h0C});
    push({1'b0, 8'h06});
    push({1'b0, 8'h01});
    rise_base = edge_n;
    rise_pend = 1'b1;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    do begin
      step(cur_v, 1'b0);
      n++;
    end while ((edge_n < idle_from || exp_q.size() != 0) && n < limit);
    if (n >= limit) check("idle_timeout", 32'(n), 32'(limit - 1));
  endtask

  // Monitor: each E rise consumes one expected byte
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        e_prev = 1'b0;
        e_len = 0;
      end else begin
        if (bus.lcd_e && !e_prev) begin
          e_len = 1;
          if (rise_pend) begin
            check("first_e_edge", 32'(edge_n - rise_base), 32'(FIRST_E));
            rise_pend = 1'b0;
          end
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            cur_byte = {bus.lcd_rs, bus.lcd_db};
            $display("FAIL unexpected_byte: got rs=%b db=%h expected none at t=%0t",
                     bus.lcd_rs, bus.lcd_db, $time);
          end else begin
            cur_byte = exp_q.pop_front();
            check("byte", 32'({bus.lcd_rs, bus.lcd_db}), 32'(cur_byte));
          end
        end else if (bus.lcd_e) begin
          e_len++;
        end else if (e_prev) begin
          check("e_width", 32'(e_len), 32'(EN));
          check("db_stable", 32'({bus.lcd_rs, bus.lcd_db}), 32'(cur_byte));
        end
        e_prev = bus.lcd_e;
      end
    end
  end

  initial begin : stim
    logic [31:0] v;
    bus.value = 32'h0;
    bus.start = 1'b0;
    repeat (3) step(32'h0, 1'b0);
    check("rst_db", 32'(bus.lcd_db), 32'h0);
    check("rst_e", 32'(bus.lcd_e), 32'h0);

    // Power-up and init, with requests that must be dropped
    release_reset();
    for (int i = 0; i < int'(INIT_CYC) - 2; i++)
      step(32'h0, ($urandom_range(0, 3) == 0));
    wait_idle(200);

    // Directed word, then ignored requests while writing
    step(32'h1234ABCD, 1'b1);
    for (int i = 0; i < 30; i++) step(32'hFFFFFFFF, 1'(i % 2));
    wait_idle(300);

    // Value changes right after latching
    step(32'h89ABCDEF, 1'b1);
    step(32'h00000000, 1'b0);
    wait_idle(300);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      v = ($urandom_range(0, 39) == 0) ? $urandom : cur_v;
      step(v, ($urandom_range(0, 7) == 0));
    end
    wait_idle(300);

    // Reset while E is high for the third data byte
    step(32'h5A5A0F3C, 1'b1);
    while (edge_n < acc_edge + 23) step(cur_v, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    idle_from = NEVER;
    exp_q.delete();
    #1;
    check("midreset_e", 32'(bus.lcd_e), 32'h0);
    check("midreset_busy", 32'(bus.busy), 32'h1);
    repeat (2) step(cur_v, 1'b0);
    release_reset();
    wait_idle(400);

    // Value change with no request, then a forced rewrite
    step(32'h0000000A, 1'b0);
    wait_idle(200);
    repeat (30) step(cur_v, 1'b0);
    step(cur_v, 1'b1);
    wait_idle(200);

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
